// File: rtl/d_cache_2way.sv
// d_cache_2way: 2-way set-associative data cache, LRU replacement, multi-word
// lines. Loads go through a lookup/refill FSM; stores update hit lines only.
// Optional hit/miss counters are enabled with the DCACHE_STATS_EN macro.
module d_cache_2way #(
  parameter int SETS           = 64,
  parameter int LINE_WORDS     = 4,
  parameter int CACHEABLE_BITS = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  output logic        ld_ready,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  input  logic        st_en,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [3:0]  st_be,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);
  localparam int OB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(SETS);
  localparam int TB = CACHEABLE_BITS - 2 - OB - IB;
  localparam logic [OB-1:0] LAST = OB'(LINE_WORDS - 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, BYPASS, RESP} state_t;
  state_t state;

  // Storage: data and tags are not reset, valid/LRU are
  logic [31:0]   data_mem [2][SETS][LINE_WORDS];
  logic [TB-1:0] tag_mem  [2][SETS];
  logic [SETS-1:0] vld [2];
  logic [SETS-1:0] lru;

  logic [31:2]   ra;              // registered load address
  logic          vict;
  logic [OB-1:0] cnt;
  logic [31:0]   rbuf [LINE_WORDS];
  logic [31:0]   resp_word;
  logic [31:0]   ld_data_q;

  // Address fields of the registered load
  logic [OB-1:0] r_off;
  logic [IB-1:0] r_idx;
  logic [TB-1:0] r_tag;
  logic          r_cach;
  assign r_off  = ra[OB+1:2];
  assign r_idx  = ra[OB+IB+1:OB+2];
  assign r_tag  = ra[CACHEABLE_BITS-1:OB+IB+2];
  assign r_cach = ~|ra[31:CACHEABLE_BITS];

  // Address fields of the store
  logic [OB-1:0] s_off;
  logic [IB-1:0] s_idx;
  logic [TB-1:0] s_tag;
  logic          s_cach;
  assign s_off  = st_addr[OB+1:2];
  assign s_idx  = st_addr[OB+IB+1:OB+2];
  assign s_tag  = st_addr[CACHEABLE_BITS-1:OB+IB+2];
  assign s_cach = ~|st_addr[31:CACHEABLE_BITS];

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = &{1'b0, ld_addr[1:0], st_addr[1:0]};

  // Tag compare for the lookup and for the store
  logic hit0, hit1, lk_hit, hit_way, sh0, sh1, s_hit, s_way;
  logic [31:0] hit_word;
  assign hit0     = vld[0][r_idx] && (tag_mem[0][r_idx] == r_tag);
  assign hit1     = vld[1][r_idx] && (tag_mem[1][r_idx] == r_tag);
  assign lk_hit   = r_cach && (hit0 || hit1);
  assign hit_way  = hit1;
  assign hit_word = data_mem[hit_way][r_idx][r_off];
  assign sh0      = vld[0][s_idx] && (tag_mem[0][s_idx] == s_tag);
  assign sh1      = vld[1][s_idx] && (tag_mem[1][s_idx] == s_tag);
  assign s_hit    = s_cach && (sh0 || sh1);
  assign s_way    = sh1;

  assign st_ready = (state == IDLE);
  assign ld_ready = (state == IDLE) && !st_en && !flush;
  assign ld_valid = ((state == LOOKUP) && lk_hit) || (state == RESP);
  assign ld_data  = ((state == LOOKUP) && lk_hit) ? hit_word :
                    (state == RESP) ? resp_word : ld_data_q;

  // Main FSM: lookup, line refill, uncached bypass and array updates
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vld[0]    <= '0;
      vld[1]    <= '0;
      lru       <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      cnt       <= '0;
      ld_data_q <= '0;
`ifdef DCACHE_STATS_EN
      hit_cnt   <= '0;
      miss_cnt  <= '0;
`endif
    end else begin
      if (ld_valid) ld_data_q <= ld_data;
      case (state)
        IDLE: begin
          if (flush) begin
            vld[0] <= '0;
            vld[1] <= '0;
            lru    <= '0;
          end else if (st_en) begin
            if (s_hit)
              for (int b = 0; b < 4; b++)
                if (st_be[b])
                  data_mem[s_way][s_idx][s_off][8*b +: 8] <= st_data[8*b +: 8];
          end else if (ld_req) begin
            ra    <= ld_addr[31:2];
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (lk_hit) begin
            lru[r_idx] <= ~hit_way;
            state      <= IDLE;
`ifdef DCACHE_STATS_EN
            hit_cnt    <= hit_cnt + 32'd1;
`endif
          end else begin
`ifdef DCACHE_STATS_EN
            miss_cnt <= miss_cnt + 32'd1;
`endif
            mem_req <= 1'b1;
            cnt     <= '0;
            if (r_cach) begin
              vict     <= !vld[0][r_idx] ? 1'b0 : !vld[1][r_idx] ? 1'b1 : lru[r_idx];
              mem_addr <= {{(32-CACHEABLE_BITS){1'b0}}, r_tag, r_idx, {OB{1'b0}}, 2'b00};
              state    <= REFILL;
            end else begin
              mem_addr <= {ra, 2'b00};
              state    <= BYPASS;
            end
          end
        end
        REFILL: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_addr <= {{(32-CACHEABLE_BITS){1'b0}}, r_tag, r_idx, cnt, 2'b00};
          end else if (mem_ack) begin
            mem_req   <= 1'b0;
            rbuf[cnt] <= mem_rdata;
            cnt       <= cnt + OB'(1);
            if (cnt == LAST) begin
              for (int w = 0; w < LINE_WORDS; w++)
                data_mem[vict][r_idx][w] <= (OB'(w) == cnt) ? mem_rdata : rbuf[w];
              tag_mem[vict][r_idx] <= r_tag;
              vld[vict][r_idx]     <= 1'b1;
              lru[r_idx]           <= ~vict;
              resp_word            <= (r_off == cnt) ? mem_rdata : rbuf[r_off];
              state                <= RESP;
            end
          end
        end
        BYPASS: begin
          if (mem_req && mem_ack) begin
            mem_req   <= 1'b0;
            resp_word <= mem_rdata;
            state     <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_d_cache_2way.sv
// Self-checking bench for d_cache_2way: directed scenarios plus randomized
// load/store/flush traffic against a recency-list cache model.
module tb_d_cache_2way;
  localparam int SETS = 64, LW = 4, CB = 17;

  logic        clk, rst;
  logic        ld_req, ld_ready, ld_valid;
  logic [31:0] ld_addr, ld_data;
  logic        st_en, st_ready;
  logic [31:0] st_addr, st_data;
  logic [3:0]  st_be;
  logic        flush, mem_req, mem_ack;
  logic [31:0] mem_addr, mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  d_cache_2way #(.SETS(SETS), .LINE_WORDS(LW), .CACHEABLE_BITS(CB)) dut (
    .clk(clk), .rst(rst), .ld_req(ld_req), .ld_addr(ld_addr), .ld_ready(ld_ready),
    .ld_valid(ld_valid), .ld_data(ld_data), .st_en(st_en), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_be(st_be), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef DCACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  int unsigned rec [SETS][$];          // cached line bases per set, MRU first
  logic [31:0] cdata [int unsigned];   // cached word contents by word address
  logic [31:0] memo  [int unsigned];   // memory words that differ from the hash
  int unsigned exp_addrs [$];          // memory fetches still expected
  int unsigned mdl_hits = 0, mdl_misses = 0;

  function automatic logic [31:0] mem_word(int unsigned a);
    if (memo.exists(a)) return memo[a];
    return (a * 32'h9E3779B1) ^ 32'hC3A50F1E;
  endfunction

  function automatic bit cacheable(int unsigned a);
    return (a >> CB) == 0;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++) rec[s].delete();
    cdata.delete();
  endfunction

  function automatic void model_load(int unsigned a, output bit hit, output logic [31:0] d);
    int unsigned w = a & ~32'd3;
    int unsigned base = a & ~32'(LW*4-1);
    int s = int'((a / (LW*4)) % SETS);
    int idx = -1;
    hit = 0;
    if (!cacheable(a)) begin
      mdl_misses++;
      exp_addrs.push_back(w);
      d = mem_word(w);
      return;
    end
    foreach (rec[s][i]) if (rec[s][i] == base) idx = i;
    if (idx >= 0) begin
      hit = 1;
      mdl_hits++;
      rec[s].delete(idx);
      rec[s].push_front(base);
    end else begin
      mdl_misses++;
      for (int k = 0; k < LW; k++) begin
        exp_addrs.push_back(base + 4*k);
        cdata[base + 4*k] = mem_word(base + 4*k);
      end
      if (rec[s].size() == 2) begin
        int unsigned ev = rec[s].pop_back();
        for (int k = 0; k < LW; k++) cdata.delete(ev + 4*k);
      end
      rec[s].push_front(base);
    end
    d = cdata[w];
  endfunction

  function automatic void model_store(int unsigned a, logic [31:0] d, logic [3:0] be);
    int unsigned w = a & ~32'd3;
    logic [31:0] t;
    if (cacheable(a) && cdata.exists(w)) begin
      t = cdata[w];
      for (int b = 0; b < 4; b++) if (be[b]) t[8*b +: 8] = d[8*b +: 8];
      cdata[w] = t;
    end
  endfunction

  // ---------------- memory responder ----------------
  int ack_delay = 0, wcnt = 0;
  bit rand_dly = 0, spurious = 0;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      mem_ack = 1'b0; wcnt = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0; wcnt = 0;
    end else if (mem_req) begin
      if (wcnt >= ack_delay) begin
        mem_ack = 1'b1;
        mem_rdata = mem_word(mem_addr);
        wcnt = 0;
        if (rand_dly) ack_delay = $urandom_range(0, 3);
      end else wcnt++;
    end else if (spurious && $urandom_range(0, 7) == 0) begin
      mem_ack = 1'b1;
      mem_rdata = $urandom;
    end
  end

  // ---------------- compare process ----------------
  bit pending = 0, exp_hit = 0, waiting = 0, use_lit = 0, in_req = 0, mon_off = 1;
  logic [31:0] exp_data, lit_data, req_a, last_data = '0;
  int lat = 0, ack_cnt = 0;

  always @(negedge clk) begin
    if (!mon_off) begin
      if (waiting) lat++;
      if (mem_req) begin
        if (!in_req) begin
          if (exp_addrs.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_mem_req: got addr %h, no fetch expected", mem_addr);
          end else chk("mem_addr", mem_addr, exp_addrs.pop_front());
          in_req = 1;
          req_a  = mem_addr;
        end else chk("mem_addr_stable", mem_addr, req_a);
        if (mem_ack) begin in_req = 0; ack_cnt++; end
      end else in_req = 0;
      if (ld_valid) begin
        if (!pending) begin
          tests++; fails++;
          $display("FAIL spurious_ld_valid: got 1 required 0");
        end else begin
          chk("ld_data", ld_data, exp_data);
          if (use_lit) chk("ld_data_literal", ld_data, lit_data);
          if (exp_hit) chk("hit_latency", lat, 1);
          chk("fetches_left", exp_addrs.size(), 0);
          pending = 0;
          waiting = 0;
        end
        last_data = ld_data;
      end else chk("ld_data_hold", ld_data, last_data);
      if (ld_req && ld_ready) begin waiting = 1; lat = 0; end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue_load(int unsigned a, bit ul, logic [31:0] lit);
    bit h; logic [31:0] d; int t;
    model_load(a, h, d);
    exp_hit = h; exp_data = d; use_lit = ul; lit_data = lit; pending = 1;
    ld_addr = a; ld_req = 1'b1;
    @(negedge clk);
    t = 0;
    while (!ld_ready && t < 50) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    ld_req = 1'b0; ld_addr = $urandom;
  endtask

  task automatic wait_load();
    int t = 0;
    while (pending && t < 400) begin @(posedge clk); #1; t++; end
    if (pending) begin
      tests++; fails++;
      $display("FAIL load_timeout: got no ld_valid within 400 cycles");
      pending = 0; waiting = 0; exp_addrs.delete();
    end
  endtask

  task automatic do_load(int unsigned a, bit ul, logic [31:0] lit, int beats);
    int a0 = ack_cnt;
    issue_load(a, ul, lit);
    wait_load();
    if (beats >= 0) chk("fetch_beats", ack_cnt - a0, beats);
  endtask

  task automatic do_store(int unsigned a, logic [31:0] d, logic [3:0] be);
    model_store(a, d, be);
    st_en = 1'b1; st_addr = a; st_data = d; st_be = be;
    @(negedge clk);
    chk("st_ready", st_ready, 1);
    chk("ld_ready_during_store", ld_ready, 0);
    @(posedge clk); #1;
    st_en = 1'b0;
  endtask

  task automatic do_flush();
    model_clear();
    flush = 1'b1;
    @(negedge clk);
    chk("ld_ready_during_flush", ld_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic do_reset(int n);
    mon_off = 1; rst = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    rst = 1'b0;
    model_clear(); exp_addrs.delete();
    pending = 0; waiting = 0; in_req = 0; last_data = '0;
    mdl_hits = 0; mdl_misses = 0;
    mon_off = 0;
  endtask

  task automatic check_stats();
`ifdef DCACHE_STATS_EN
    chk("hit_cnt", hit_cnt, mdl_hits);
    chk("miss_cnt", miss_cnt, mdl_misses);
`endif
  endtask

  function automatic int unsigned rand_addr();
    int unsigned a = ($urandom_range(0, 2) * SETS * LW * 4) + ($urandom_range(3, 5) * LW * 4)
                     + ($urandom_range(0, LW-1) * 4) + ($urandom & 3);
    if ($urandom_range(0, 9) == 0) a = a | (32'd1 << $urandom_range(CB, 31));
    return a;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int a0, t;
    rst = 1'b1; ld_req = 0; ld_addr = 0; st_en = 0; st_addr = 0; st_data = 0; st_be = 0;
    flush = 0; mem_ack = 0; mem_rdata = 0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("rst_ld_valid", ld_valid, 0);
    chk("rst_ld_data", ld_data, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_st_ready", st_ready, 1);
    check_stats();
    @(posedge clk); #1;
    rst = 1'b0; mon_off = 0;

    // cold miss then hit
    for (int k = 0; k < 4; k++) memo[32'h100 + 4*k] = 32'hA0 + k;
    memo[32'h500] = 32'h55;
    memo[32'h30000] = 32'hDEADBEEF;
    do_load(32'h104, 1, 32'hA1, 4);
    do_load(32'h10C, 1, 32'hA3, 0);
    // store merge into a hit line
    do_store(32'h108, 32'h0000BB00, 4'b0010);
    do_load(32'h108, 1, 32'h0000BBA2, 0);
    // store to an uncached line does not allocate
    do_store(32'h504, 32'h12345678, 4'b1111);
    do_load(32'h500, 1, 32'h55, 4);
    // LRU: 0x100 and 0x500 share a set; touch 0x100, bring in 0x900
    do_load(32'h100, 1, 32'hA0, 0);
    do_load(32'h900, 0, 0, 4);
    do_load(32'h100, 1, 32'hA0, 0);
    do_load(32'h500, 1, 32'h55, 4);
    // uncacheable bypass, never allocated
    do_load(32'h30000, 1, 32'hDEADBEEF, 1);
    do_load(32'h30000, 1, 32'hDEADBEEF, 1);
    check_stats();
    // flush forces a refill
    do_flush();
    do_load(32'h100, 1, 32'hA0, 4);
    // reset after the second refill ack aborts the refill
    a0 = ack_cnt;
    issue_load(32'hD00, 0, 0);
    t = 0;
    while (ack_cnt - a0 < 2 && t < 100) begin @(posedge clk); #1; t++; end
    chk("acks_before_reset", ack_cnt - a0, 2);
    mon_off = 1; rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mem_req_after_rst", mem_req, 0);
    chk("ld_valid_after_rst", ld_valid, 0);
    @(posedge clk); #1;
    do_reset(1);
    do_load(32'hD00, 0, 0, 4);
    // stalled memory: address must hold for every wait cycle
    ack_delay = 5;
    do_load(32'h2040, 0, 0, 4);
    do_load(32'h2044, 0, 0, 0);
    ack_delay = 0;
    check_stats();

    // randomized traffic
    rand_dly = 1; spurious = 1;
    for (int i = 0; i < 400; i++) begin
      int r = $urandom_range(0, 99);
      if (r < 60) do_load(rand_addr(), 0, 0, -1);
      else if (r < 85) do_store(rand_addr(), $urandom, 4'($urandom));
      else if (r < 90) do_flush();
      else if (r < 91) do_reset(2);
      else begin @(posedge clk); #1; end
    end
    rand_dly = 0; spurious = 0;
    repeat (3) begin @(posedge clk); #1; end
    check_stats();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    fails++;
    $display("FAIL global_timeout: got no completion, required finish before 90000 cycles");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/d_cache_2way.md
Name: d_cache_2way

Overview:
- Second-generation data cache for the RISC-V core: parametrised 2-way set-associative, LRU replacement, multi-word lines.
- Sits between the load/store unit and the memory controller.
- Loads use a req/ready/valid handshake, with a refill FSM on a miss.
- Stores are write-through at the LSU; this block only updates hit lines with a byte-enable merge (no write-allocate).

Parameters:
- SETS, 64: number of sets, power of two ≥2; INDEX_BITS=log2(SETS).
- LINE_WORDS, 4: 32-bit words per line, power of two ≥2; OFFSET_BITS=log2(LINE_WORDS).
- CACHEABLE_BITS, 17: an address is cacheable iff addr[31:CACHEABLE_BITS]==0; TAG_BITS=CACHEABLE_BITS-2-OFFSET_BITS-INDEX_BITS (default 7).

Ports:
- clk  in  1  clock
- rst  in  1  reset (synchronous, active-high)
- ld_req  in  1  load request
- ld_addr  in  32  load address; bits [1:0] ignored
- ld_ready  out  1  load accepted when ld_req&&ld_ready
- ld_valid  out  1  one-cycle pulse, ld_data valid
- ld_data  out  32  loaded word
- st_en  in  1  store update; taken only when st_ready
- st_ready  out  1  store accepted
- st_addr  in  32  store address
- st_data  in  32  store data, lane-aligned
- st_be  in  4  byte enables
- flush  in  1  invalidate all lines
- mem_req  out  1  word read request to memory controller
- mem_addr  out  32  word address, [1:0]=0
- mem_ack  in  1  mem_rdata valid this cycle; ends the request
- mem_rdata  in  32  returned word

Behaviour:
- Reset: all valid bits=0, LRU bits=0, state IDLE. ld_valid=0, ld_data=0, mem_req=0, mem_addr=0. Data and tag arrays are not reset.
- States: IDLE, LOOKUP, REFILL, BYPASS, RESP.
- Address split: offset=addr[OFFSET_BITS+1:2], index=next INDEX_BITS bits, tag=next TAG_BITS bits.
- Ready signals:
  - st_ready = (state==IDLE).
  - ld_ready = IDLE && !st_en && !flush.
  - Priority in IDLE: flush > store > load.
- flush (IDLE): clears every valid bit and every LRU bit at the edge.
- Store (IDLE, st_en):
  - If the tag matches a valid way in its set and the address is cacheable, merge st_data bytes where st_be=1 into that word at the edge.
  - Otherwise no change; no allocate; LRU unchanged.
- Load accept (edge N): register the address and go to LOOKUP.
- LOOKUP (cycle N+1): compare tags in both ways of the registered set.
  - Hit (cacheable): ld_valid=1 and ld_data=word in this cycle (latency 1); LRU[set]=index of the other way; go IDLE.
  - Miss, cacheable: go REFILL with word counter=0; victim = invalid way 0, else invalid way 1, else way LRU[set].
  - Miss, uncacheable: go BYPASS.
- REFILL:
  - mem_req=1, mem_addr={tag,index,counter,2'b00}; hold both stable until mem_ack.
  - On mem_ack: capture word[counter], increment counter. mem_req stays low for the ack cycle; next request starts the following cycle.
  - After word LINE_WORDS-1 is acked: write the whole line, tag and valid=1 into the victim; LRU[set]=other way; go RESP.
- BYPASS: one mem_req for the exact word; no array update; on mem_ack go RESP.
- RESP: ld_valid=1, ld_data=the requested word from the refill buffer or bypass word; go IDLE.
- ld_data holds its last value when ld_valid=0.
- Counter wrap: the counter is OFFSET_BITS wide; the line is complete when the counter wraps to 0 on an ack.
- mem_ack with mem_req=0 is ignored.
- rst during REFILL/BYPASS: abort immediately; mem_req=0 next cycle; partial line discarded; nothing written.

Optional Feature:
- Macro DCACHE_STATS_EN.
- Defined: adds outputs hit_cnt[31:0] and miss_cnt[31:0].
  - hit_cnt increments on each LOOKUP hit; miss_cnt on each LOOKUP miss, cacheable or not.
  - Both reset to 0 on rst; neither is cleared by flush; both wrap at 2^32.
- Undefined: ports and counters are absent; behaviour otherwise identical.

Test Plan:
- Cold miss then hit: load 0x00000104, memory returns 0xA0,0xA1,0xA2,0xA3 for words 0x100..0x10C.
  - Expect 4 mem_req beats at 0x100,0x104,0x108,0x10C, then RESP ld_data=0xA1.
  - Reload 0x10C: ld_valid at N+1 with 0xA3, no mem_req.
- Store merge: after the fill above, store st_addr=0x108, st_data=0x0000BB00, st_be=4'b0010; then load 0x108 -> 0x0000BBA2.
  - Store to an uncached line: no array change, a later load of that line misses.
- LRU eviction: fill 0x100 and 0x100+SETS*16 (same set), hit 0x100, then load 0x100+2*SETS*16.
  - Expect way holding the second line evicted: 0x100 still hits, second line misses.
- Bypass: load 0x00030000.
  - Expect single mem_req at 0x00030000, ld_data=mem_rdata, repeat load misses again.
- Flush/reset: flush after a fill -> next load to the same address refills.
  - Assert rst after the 2nd refill ack -> mem_req=0 next cycle, later load refills all 4 words.
- Stall timing: mem_ack delayed 5 cycles.
  - Expect mem_addr stable throughout; with DCACHE_STATS_EN, hit_cnt and miss_cnt match the counted LOOKUP outcomes.
